// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: RV32M funct3 ops,
// FSM states and the default datapath width.
package ex_muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/ex_muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring-divide step on the
// {hi, lo} working pair. Purely combinational so it can be chained.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0] sum;
    logic [XLEN:0] rem_sh;
    logic          ge;

    always_comb begin
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
        rem_sh = {hi, lo[XLEN-1]};
        ge     = rem_sh >= {1'b0, operand};
        if (is_div) begin
            // hi holds the partial remainder, lo shifts dividend out / quotient in
            hi_next = ge ? XLEN'(rem_sh - {1'b0, operand}) : rem_sh[XLEN-1:0];
            lo_next = {lo[XLEN-2:0], ge};
        end else begin
            hi_next = sum[XLEN:1];
            lo_next = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: magnitudes are processed UNROLL bits
// per cycle, signs are re-applied at the end; div-by-zero/overflow bypass CALC.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    input  logic [4:0]      waddr_in,
    input  logic            flush,
    output logic            stall_req,
    output logic            we,
    output logic [4:0]      waddr,
    output logic [XLEN-1:0] wdata
);

    localparam int ITER = XLEN / UNROLL;
    localparam int CW   = $clog2(ITER) + 1;

    state_e          state;
    logic [CW-1:0]   cnt;
    op_e             op_q;
    logic [4:0]      waddr_q;
    logic [XLEN-1:0] opnd, hi, lo;
    logic            neg_q, neg_r;

    op_e             op_i;
    logic            div_i, sign_a, sign_b, div_zero, ovf, special, accept;
    logic [XLEN-1:0] mag_a, mag_b, special_res;

    always_comb begin
        op_i     = op_e'(op);
        div_i    = op[2];
        sign_a   = data1[XLEN-1] & (op_i inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        sign_b   = data2[XLEN-1] & (op_i inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
        mag_a    = sign_a ? -data1 : data1;
        mag_b    = sign_b ? -data2 : data2;
        div_zero = div_i && (data2 == '0);
        ovf      = (op_i inside {OP_DIV, OP_REM}) && (data1 == {1'b1, {(XLEN-1){1'b0}}})
                   && (data2 == '1);
        special  = div_zero | ovf;
        if (div_zero)
            special_res = (op_i inside {OP_DIV, OP_DIVU}) ? '1 : data1;
        else
            special_res = (op_i == OP_DIV) ? data1 : '0;
        accept    = rst & start & rdy & ~flush & (state != S_CALC);
        stall_req = (state == S_CALC) | (accept & ~special);
    end

    logic [UNROLL:0][XLEN-1:0] hi_c, lo_c;
    assign hi_c[0] = hi;
    assign lo_c[0] = lo;

    for (genvar g = 0; g < UNROLL; g++) begin : g_step
        muldiv_step #(.XLEN(XLEN)) u_step (
            .is_div  (op_q[2]),
            .hi      (hi_c[g]),
            .lo      (lo_c[g]),
            .operand (opnd),
            .hi_next (hi_c[g+1]),
            .lo_next (lo_c[g+1])
        );
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   calc_res;

    always_comb begin
        prod = {hi_c[UNROLL], lo_c[UNROLL]};
        if (neg_q) prod = -prod;
        case (op_q)
            OP_MUL:                        calc_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  calc_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               calc_res = neg_q ? -lo_c[UNROLL] : lo_c[UNROLL];
            default:                       calc_res = neg_r ? -hi_c[UNROLL] : hi_c[UNROLL];
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            op_q    <= OP_MUL;
            waddr_q <= '0;
            opnd    <= '0;
            hi      <= '0;
            lo      <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            we      <= 1'b0;
            waddr   <= '0;
            wdata   <= '0;
        end else if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
            we    <= 1'b0;
        end else if (rdy) begin
            we <= 1'b0;
            case (state)
                S_CALC: begin
                    hi <= hi_c[UNROLL];
                    lo <= lo_c[UNROLL];
                    if (cnt == CW'(ITER - 1)) begin
                        state <= S_DONE;
                        we    <= 1'b1;
                        waddr <= waddr_q;
                        wdata <= calc_res;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    if (start) begin
                        op_q    <= op_i;
                        waddr_q <= waddr_in;
                        neg_q   <= sign_a ^ sign_b;
                        neg_r   <= sign_a;
                        hi      <= '0;
                        lo      <= div_i ? mag_a : mag_b;
                        opnd    <= div_i ? mag_b : mag_a;
                        cnt     <= '0;
                        if (special) begin
                            state <= S_DONE;
                            we    <= 1'b1;
                            waddr <= waddr_in;
                            wdata <= special_res;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: a transaction-level latency/result model checked every
// cycle, plus directed vectors with hand-computed results and latencies.
module tb_ex_muldiv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v[2], rdy_v[2], start_v[2], flush_v[2];
    logic [2:0]  op_v[2];
    logic [31:0] d1_v[2], d2_v[2];
    logic [4:0]  wa_in_v[2];
    logic        stall_v[2], we_v[2];
    logic [4:0]  wa_v[2];
    logic [31:0] wd_v[2];

    ex_muldiv #(.XLEN(32), .UNROLL(1)) dut0 (
        .clk(clk), .rst(rst_v[0]), .rdy(rdy_v[0]), .start(start_v[0]), .op(op_v[0]),
        .data1(d1_v[0]), .data2(d2_v[0]), .waddr_in(wa_in_v[0]), .flush(flush_v[0]),
        .stall_req(stall_v[0]), .we(we_v[0]), .waddr(wa_v[0]), .wdata(wd_v[0])
    );

    ex_muldiv #(.XLEN(32), .UNROLL(4)) dut1 (
        .clk(clk), .rst(rst_v[1]), .rdy(rdy_v[1]), .start(start_v[1]), .op(op_v[1]),
        .data1(d1_v[1]), .data2(d2_v[1]), .waddr_in(wa_in_v[1]), .flush(flush_v[1]),
        .stall_req(stall_v[1]), .we(we_v[1]), .waddr(wa_v[1]), .wdata(wd_v[1])
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic is_special(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
        return o[2] && (b == 32'd0 || ((o == 3'd4 || o == 3'd6) &&
                        a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, ub, p;
        logic [63:0] pu;
        logic ovfl;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        ovfl = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovfl) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovfl) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Transaction model: an accepted op completes after a fixed number of
    // enabled edges (1 for special cases) and is visible for one DONE cycle.
    bit          busy[2], done[2];
    int          remain[2];
    logic [31:0] rpend[2], rout[2];
    logic [4:0]  wpend[2], wout[2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_v[d] || flush_v[d]) begin
                busy[d] = 0;
                done[d] = 0;
            end else if (rdy_v[d]) begin
                bit nd;
                nd = 0;
                if (busy[d]) begin
                    remain[d]--;
                    if (remain[d] == 0) begin
                        busy[d] = 0; nd = 1; rout[d] = rpend[d]; wout[d] = wpend[d];
                    end
                end else if (start_v[d]) begin
                    if (is_special(op_v[d], d1_v[d], d2_v[d])) begin
                        nd = 1;
                        rout[d] = ref_res(op_v[d], d1_v[d], d2_v[d]);
                        wout[d] = wa_in_v[d];
                    end else begin
                        busy[d] = 1;
                        remain[d] = (d == 0) ? 32 : 8;
                        rpend[d] = ref_res(op_v[d], d1_v[d], d2_v[d]);
                        wpend[d] = wa_in_v[d];
                    end
                end
                done[d] = nd;
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_v[d]) begin
                chk($sformatf("rst_stall%0d", d), 32'(stall_v[d]), 32'd0);
                chk($sformatf("rst_we%0d", d), 32'(we_v[d]), 32'd0);
                chk($sformatf("rst_wdata%0d", d), wd_v[d], 32'd0);
            end else begin
                logic es;
                es = busy[d] || (start_v[d] && rdy_v[d] && !flush_v[d] &&
                     !is_special(op_v[d], d1_v[d], d2_v[d]));
                chk($sformatf("stall%0d", d), 32'(stall_v[d]), 32'(es));
                chk($sformatf("we%0d", d), 32'(we_v[d]), 32'(done[d]));
                if (done[d]) begin
                    chk($sformatf("wdata%0d", d), wd_v[d], rout[d]);
                    chk($sformatf("waddr%0d", d), 32'(wa_v[d]), 32'(wout[d]));
                end
            end
        end
    end

    task automatic issue(input int d, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] w, input int roff,
                         input int rlen, output int lat, output int stalls,
                         output logic [31:0] res);
        int k;
        lat = -1; stalls = 0; res = '0; k = 0;
        @(posedge clk); #1;
        start_v[d] = 1; op_v[d] = o; d1_v[d] = a; d2_v[d] = b; wa_in_v[d] = w;
        @(negedge clk);
        while (k < 100) begin
            if (we_v[d]) begin lat = k; res = wd_v[d]; break; end
            if (stall_v[d]) stalls++;
            @(posedge clk); #1;
            k++;
            start_v[d] = 0;
            rdy_v[d] = !(k >= roff && k < roff + rlen);
            @(negedge clk);
        end
        start_v[d] = 0;
        rdy_v[d] = 1;
    endtask

    int lat, st, k, nwe, lat1, lat2;
    logic [31:0] res, r1, r2;

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_v[d] = 0; rdy_v[d] = 1; start_v[d] = 0; flush_v[d] = 0;
            op_v[d] = 0; d1_v[d] = 0; d2_v[d] = 0; wa_in_v[d] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("reset_we", 32'(we_v[0]), 32'd0);
        chk("reset_wdata", wd_v[0], 32'd0);
        chk("reset_stall", 32'(stall_v[0]), 32'd0);
        rst_v[0] = 1; rst_v[1] = 1;

        issue(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1000, 0, lat, st, res);
        chk("mul_res", res, 32'hFFFF_FFEB);
        chk("mul_lat", lat, 33);
        chk("mul_stall_cycles", st, 33);

        issue(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1000, 0, lat, st, res);
        chk("mulhu_res", res, 32'hFFFF_FFFE);
        issue(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1000, 0, lat, st, res);
        chk("mulhsu_res", res, 32'hFFFF_FFFF);
        chk("mulhsu_lat", lat, 33);

        issue(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1000, 0, lat, st, res);
        chk("div_ovf_res", res, 32'h8000_0000);
        chk("div_ovf_lat", lat, 1);
        chk("div_ovf_stall", st, 0);
        issue(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1000, 0, lat, st, res);
        chk("rem_ovf_res", res, 32'd0);
        chk("rem_ovf_lat", lat, 1);
        issue(0, 3'd5, 32'd100, 32'd0, 5'd10, 1000, 0, lat, st, res);
        chk("divu_zero_res", res, 32'hFFFF_FFFF);
        chk("divu_zero_lat", lat, 1);
        chk("divu_zero_stall", st, 0);
        issue(0, 3'd6, 32'hFFFF_FFF9, 32'd0, 5'd11, 1000, 0, lat, st, res);
        chk("rem_zero_res", res, 32'hFFFF_FFF9);
        chk("rem_zero_stall", st, 0);

        issue(0, 3'd4, 32'hFFFF_FFEC, 32'd3, 5'd12, 10, 5, lat, st, res);
        chk("div_neg_res", res, 32'hFFFF_FFFA);
        chk("div_rdy_lat", lat, 38);
        issue(0, 3'd6, 32'hFFFF_FFEC, 32'd3, 5'd13, 1000, 0, lat, st, res);
        chk("rem_neg_res", res, 32'hFFFF_FFFE);
        chk("rem_neg_lat", lat, 33);

        // Flush at CALC cycle 10, then restart right after the quiet cycle.
        @(posedge clk); #1;
        start_v[0] = 1; op_v[0] = 3'd4; d1_v[0] = 32'd100; d2_v[0] = 32'd7; wa_in_v[0] = 5'd14;
        nwe = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            start_v[0] = 0;
            flush_v[0] = (i == 10);
            @(negedge clk);
            if (we_v[0]) nwe++;
        end
        @(posedge clk); #1;
        flush_v[0] = 0;
        @(negedge clk);
        chk("flush_stall_next", 32'(stall_v[0]), 32'd0);
        chk("flush_no_we", 32'(nwe + int'(we_v[0])), 32'd0);
        issue(0, 3'd5, 32'd1000, 32'd7, 5'd15, 1000, 0, lat, st, res);
        chk("after_flush_res", res, 32'd142);
        chk("after_flush_lat", lat, 33);

        // Reset pulse mid-CALC: outputs clear at once, nothing is written back.
        @(posedge clk); #1;
        start_v[0] = 1; op_v[0] = 3'd0; d1_v[0] = 32'd3; d2_v[0] = 32'd5; wa_in_v[0] = 5'd16;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            start_v[0] = 0;
        end
        rst_v[0] = 0;
        #1;
        chk("rst_async_stall", 32'(stall_v[0]), 32'd0);
        chk("rst_async_we", 32'(we_v[0]), 32'd0);
        chk("rst_async_wdata", wd_v[0], 32'd0);
        @(posedge clk); #1;
        rst_v[0] = 1;
        nwe = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (we_v[0]) nwe++;
        end
        chk("rst_no_we", nwe, 0);

        // UNROLL=4: back-to-back, second start issued in the DONE cycle.
        @(posedge clk); #1;
        start_v[1] = 1; op_v[1] = 3'd5; d1_v[1] = 32'd1000; d2_v[1] = 32'd7; wa_in_v[1] = 5'd3;
        k = 0; lat1 = -1; lat2 = -1; r1 = '0; r2 = '0;
        while (k < 30) begin
            @(negedge clk);
            if (we_v[1]) begin
                if (lat1 < 0) begin lat1 = k; r1 = wd_v[1]; end
                else if (lat2 < 0) begin lat2 = k; r2 = wd_v[1]; end
            end
            @(posedge clk); #1;
            k++;
            start_v[1] = (k == 9);
            if (k == 9) begin
                op_v[1] = 3'd0; d1_v[1] = 32'd3; d2_v[1] = 32'd5; wa_in_v[1] = 5'd4;
            end
        end
        chk("u4_divu_res", r1, 32'd142);
        chk("u4_divu_lat", lat1, 9);
        chk("u4_mul_res", r2, 32'd15);
        chk("u4_mul_lat", lat2, 18);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter UNROLL, default 1, iterations per cycle; legal values 1, 2, 4; XLEN divisible by UNROLL.
REQ-003 SHALL have port clk  in  1  single clock; all state on posedge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rdy  in  1  global enable; low freezes all state.
REQ-006 SHALL have port start  in  1  request valid.
REQ-007 SHALL have port op  in  3  RV32M funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-008 SHALL have port data1  in  XLEN  rs1 operand.
REQ-009 SHALL have port data2  in  XLEN  rs2 operand.
REQ-010 SHALL have port waddr_in  in  5  destination register.
REQ-011 SHALL have port flush  in  1  abort the in-flight operation.
REQ-012 SHALL have port stall_req  out  1  pipeline hold request.
REQ-013 SHALL have port we  out  1  writeback valid; one-cycle pulse.
REQ-014 SHALL have port waddr  out  5  writeback register.
REQ-015 SHALL have port wdata  out  XLEN  result.

Function
REQ-016 SHALL implement FSM IDLE, CALC, DONE; start is accepted only when state is IDLE or DONE, rdy=1, flush=0.
REQ-017 SHALL latch op, waddr_in, operand magnitudes and result-sign flags on acceptance.
REQ-018 SHALL run I=XLEN/UNROLL CALC cycles: shift-add for multiply, restoring subtract for divide, UNROLL bits per cycle.
REQ-019 SHALL reach DONE I+1 edges after the accept cycle; we=1 for exactly that DONE cycle.
REQ-020 SHALL leave DONE after one cycle: to CALC if a new start is accepted, else to IDLE.
REQ-021 SHALL drive stall_req combinationally high during CALC, and during an accepting cycle with a non-special op; stall_req SHALL be low in IDLE and DONE otherwise.
REQ-022 SHALL handle divide by zero as a special case: quotient all-ones, remainder = data1, IDLE->DONE in one edge, no stall_req.
REQ-023 SHALL handle signed overflow as a special case: DIV/REM of -2^(XLEN-1) by -1 gives quotient -2^(XLEN-1) and remainder 0, IDLE->DONE in one edge.
REQ-024 SHALL form a 2*XLEN-bit product; MUL returns the low half, MULH/MULHSU/MULHU the high half, with signedness per op.
REQ-025 SHALL give the quotient the sign data1^data2 and the remainder the sign of data1 (signed ops only).
REQ-026 SHALL give flush top priority: next state IDLE, any pending we suppressed, and any start in the same cycle dropped.
REQ-027 SHALL hold state, counter and outputs unchanged while rdy=0; latency extends by the number of rdy-low cycles.
REQ-028 SHALL hold wdata/waddr valid only while we=1; their values are don't-care otherwise.

Reset
REQ-029 SHALL, on rst low, immediately clear state to IDLE and counter to 0; we=0, waddr=0, wdata=0, stall_req=0.
REQ-030 SHALL discard an operation in progress when rst asserts; no we follows reset release.

Structure
REQ-031 SHALL place the op encodings, FSM state encodings and XLEN default in the shared defines file.
REQ-032 SHALL use one sub-module, muldiv_step: a combinational single-bit iteration, instantiated UNROLL times via generate.
REQ-033 SHALL keep the iteration counter clog2(I)+1 bits wide and compare it against I-1 to leave CALC.

Verification
REQ-034 SHALL cover MUL 7 x 0xFFFFFFFD (XLEN=32, UNROLL=1) -> wdata 0xFFFFFFEB, we exactly 33 cycles after the start cycle, stall_req high for 33 cycles.
REQ-035 SHALL cover MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE, and MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-036 SHALL cover DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0, DIVU 100/0 -> 0xFFFFFFFF, REM 0xFFFFFFF9/0 -> 0xFFFFFFF9, each with we one cycle after start and stall_req never high.
REQ-037 SHALL cover DIV -20/3 -> 0xFFFFFFFA and REM -> 0xFFFFFFFE, with rdy low for 5 cycles mid-CALC -> we at cycle 38.
REQ-038 SHALL cover flush at CALC cycle 10 -> no we, stall_req low the next cycle, and a new start accepted the following cycle; then rst pulsed mid-CALC -> outputs zero at once, no we.
REQ-039 SHALL cover UNROLL=4: back-to-back DIVU 1000/7 then MUL 3x5, second start in DONE -> results 142 and 15, we 9 cycles after each start.
